// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes, debounces and edge-detects six push buttons for game_logic.
// Define INPUT_AUTOREPEAT_EN to add press auto-repeat on the up/down buttons (bits 2 and 3).
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int ACTIVE_LOW_IN = 0,
  parameter int REPEAT_DELAY = 32500000,
  parameter int REPEAT_PERIOD = 9750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] btn_raw,
  output logic [5:0] btn_level,
  output logic [5:0] btn_press,
  output logic [5:0] btn_release,
  output logic       any_press
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("input_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end
  logic [5:0] sync1, sync2, flip, stable_n, rep, press_n;
  logic [5:0][CW-1:0] cnt;
  always_comb begin
    for (int i = 0; i < 6; i++)
      flip[i] = sync2[i] != btn_level[i] && cnt[i] == CMAX;
    stable_n = btn_level ^ flip;
    press_n = (flip & stable_n) | rep;
  end
  // btn_level is the debounced stable register itself, so level and pulses move on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      cnt <= '0;
      btn_level <= '0;
      btn_press <= '0;
      btn_release <= '0;
      any_press <= 1'b0;
    end else begin
      sync1 <= btn_raw ^ {6{ACTIVE_LOW_IN != 0}};
      sync2 <= sync1;
      for (int i = 0; i < 6; i++)
        cnt[i] <= (sync2[i] == btn_level[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
      btn_level <= stable_n;
      btn_press <= press_n;
      btn_release <= flip & ~stable_n;
      any_press <= |press_n;
    end
  end
`ifdef INPUT_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  logic [1:0][RW-1:0] rc;
  logic [1:0] rph, hit, held;
  // repeats only fire while the level stays high across the edge, so they never collide with a release
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      held[j] = btn_level[j+2] && stable_n[j+2];
      hit[j] = held[j] && rc[j] == (rph[j] ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
    end
    rep = {2'b00, hit, 2'b00};
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rc <= '0;
      rph <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        rc[j] <= (!held[j] || hit[j]) ? '0 : rc[j] + 1'b1;
        rph[j] <= held[j] && (rph[j] || hit[j]);
      end
    end
  end
`else
  assign rep = '0;
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench; stimulus queues timed output events, a monitor checks them.
module tb_input_conditioner;
  logic clock, reset;
  logic [5:0] btn_raw, btn_level, btn_press, btn_release;
  logic any_press;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  typedef struct {
    int c;
    logic [5:0] p, r, l;
    logic a;
  } ev_t;
  ev_t q[$];
  ev_t e;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW_IN(0),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .any_press(any_press)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int dt, input logic [5:0] p, input logic [5:0] r,
                           input logic [5:0] l, input logic a);
    ev_t n;
    n.c = cyc + dt;
    n.p = p;
    n.r = r;
    n.l = l;
    n.a = a;
    q.push_back(n);
  endtask

  task automatic drive(input logic [5:0] v, input int hold);
    btn_raw = v;
    repeat (hold) @(negedge clock);
  endtask

  // Any pulse output is an event; it must match the head of the queue exactly, including its cycle.
  always @(negedge clock) begin
    if (reset && (btn_press != 0 || btn_release != 0 || any_press)) begin
      if (q.size() == 0) begin
        check("unexpected_event", {btn_press, btn_release, 1'b0, any_press}, 0);
      end else begin
        e = q.pop_front();
        check("event_cycle", cyc, e.c);
        check("press", btn_press, e.p);
        check("release", btn_release, e.r);
        check("level", btn_level, e.l);
        check("any_press", any_press, e.a);
        check("press_and_release", btn_press & btn_release, 0);
      end
    end
  end

  initial begin
    reset = 1'b0;
    btn_raw = '0;
    #2;
    check("rst_level", btn_level, 0);
    check("rst_press", btn_press, 0);
    check("rst_release", btn_release, 0);
    check("rst_any", any_press, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    // bit2 press then release
    expect_ev(6, 6'b000100, 0, 6'b000100, 1);
    drive(6'b000100, 10);
    expect_ev(6, 0, 6'b000100, 0, 0);
    drive(0, 10);
    // bit4 glitch of 3 cycles is rejected
    drive(6'b010000, 3);
    drive(0, 10);
    check("glitch_level", btn_level, 0);
    // bit0 bounce restarts the count
    drive(6'b000001, 2);
    drive(0, 1);
    expect_ev(6, 6'b000001, 0, 6'b000001, 1);
    drive(6'b000001, 12);
    expect_ev(6, 0, 6'b000001, 0, 0);
    drive(0, 10);
    // bits 0 and 5 together
    expect_ev(6, 6'b100001, 0, 6'b100001, 1);
    drive(6'b100001, 10);
    expect_ev(6, 0, 6'b100001, 0, 0);
    drive(0, 10);
    // reset while bit3 held and bit1 mid-count
    expect_ev(6, 6'b001000, 0, 6'b001000, 1);
    drive(6'b001000, 10);
    drive(6'b001010, 4);
    check("pre_reset_level", btn_level, 6'b001000);
    reset = 1'b0;
    btn_raw = 6'b001000;
    #1;
    check("mid_rst_level", btn_level, 0);
    check("mid_rst_press", btn_press, 0);
    check("mid_rst_release", btn_release, 0);
    check("mid_rst_any", any_press, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    expect_ev(6, 6'b001000, 0, 6'b001000, 1);
    drive(6'b001000, 10);
    expect_ev(6, 0, 6'b001000, 0, 0);
    drive(0, 10);
    // long hold on bit3 (auto-repeat candidate) and bit4 (never repeats)
    expect_ev(6, 6'b001000, 0, 6'b001000, 1);
`ifdef INPUT_AUTOREPEAT_EN
    for (int k = 0; k < 4; k++) expect_ev(26 + 8 * k, 6'b001000, 0, 6'b001000, 1);
`endif
    expect_ev(56, 0, 6'b001000, 0, 0);
    drive(6'b001000, 50);
    drive(0, 10);
    expect_ev(6, 6'b010000, 0, 6'b010000, 1);
    expect_ev(56, 0, 6'b010000, 0, 0);
    drive(6'b010000, 50);
    drive(0, 10);
    check("events_outstanding", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
